// File: rtl/seq_det_pkg.sv
// Shared encodings for the "1001" detector front-end: controller states,
// detector states and the detector transition function.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        REPORT = 2'b10
    } ctrlState_e;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } detState_e;

    // Moore "1001" with overlap; any unused code behaves as S0.
    function automatic detState_e detStep(input detState_e s, input logic b);
        case (s)
            S0:      return b ? S1 : S0;
            S1:      return b ? S1 : S2;
            S2:      return b ? S1 : S3;
            S3:      return b ? S4 : S0;
            S4:      return b ? S1 : S2;
            default: return b ? S1 : S0;
        endcase
    endfunction

endpackage

// File: rtl/pattern_1001_det.sv
// Serial Moore detector for "1001": advances only when bit_en is high, z=1 in S4.
// clr forces S0 and takes priority over bit_en.
module pattern_1001_det
    import seq_det_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic bit_en,
    input  logic bit_in,
    input  logic clr,
    output logic z,
    output logic next_is_match
);

    detState_e stateReg;
    detState_e stateNext;

    always_comb begin
        stateNext = stateReg;
        if (clr)
            stateNext = S0;
        else if (bit_en)
            stateNext = detStep(stateReg, bit_in);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stateReg <= S0;
        else
            stateReg <= stateNext;
    end

    assign z             = (stateReg == S4);
    assign next_is_match = bit_en && !clr && (stateNext == S4);

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit front-end for the "1001" detector: serializes MSB-first, counts matches per
// word and reports the count over valid/ready. Optional irq/irq_clr when SEQ_DET_IRQ_EN is defined.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
`ifdef SEQ_DET_IRQ_EN
    output logic              irq,
    input  logic              irq_clr,
`endif
    output logic              match_pulse
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    ctrlState_e        ctrlReg;
    ctrlState_e        ctrlNext;
    logic [DATA_W-1:0] wordReg;
    logic [IDX_W-1:0]  idxReg;
    logic [CNT_W-1:0]  countReg;
    logic              stepReg;
    logic              bitEn;
    logic              bitIn;
    logic              detClr;
    logic              detZ;
    logic              detMatch;

    always_comb begin
        ctrlNext = ctrlReg;
        bitEn    = 1'b0;
        detClr   = 1'b0;
        case (ctrlReg)
            IDLE: begin
                detClr = flush;
                if (in_valid)
                    ctrlNext = SHIFT;
            end
            SHIFT: begin
                bitEn = 1'b1;
                if (idxReg == LAST_IDX)
                    ctrlNext = REPORT;
            end
            REPORT: begin
                if (out_ready)
                    ctrlNext = IDLE;
            end
            default: ctrlNext = IDLE;
        endcase
    end

    assign bitIn = wordReg[LAST_IDX - idxReg];

    pattern_1001_det u_det (
        .clock         (clock),
        .reset         (reset),
        .bit_en        (bitEn),
        .bit_in        (bitIn),
        .clr           (detClr),
        .z             (detZ),
        .next_is_match (detMatch)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrlReg  <= IDLE;
            wordReg  <= '0;
            idxReg   <= '0;
            countReg <= '0;
            stepReg  <= 1'b0;
        end else begin
            ctrlReg <= ctrlNext;
            stepReg <= bitEn;
            if (ctrlReg == IDLE && in_valid) begin
                wordReg  <= in_data;
                idxReg   <= '0;
                countReg <= '0;
            end else if (ctrlReg == SHIFT) begin
                idxReg <= idxReg + IDX_W'(1);
                if (detMatch)
                    countReg <= countReg + CNT_W'(1);
            end
        end
    end

    // Detector sits in S4 exactly when the bit stepped on the previous edge completed a match.
    assign match_pulse = detZ && stepReg;
    assign in_ready    = (ctrlReg == IDLE);
    assign out_valid   = (ctrlReg == REPORT);
    assign busy        = (ctrlReg == SHIFT) || (ctrlReg == REPORT);
    assign out_count   = countReg;

`ifdef SEQ_DET_IRQ_EN
    logic irqReg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            irqReg <= 1'b0;
        else if (match_pulse)
            irqReg <= 1'b1;
        else if (irq_clr)
            irqReg <= 1'b0;
    end

    assign irq = irqReg;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a bit-history model predicts each word's match count;
// irq checks are included when SEQ_DET_IRQ_EN is defined.
module tb_seq_detect_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [CNT_W-1:0]  out_count;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              match_pulse;
`ifdef SEQ_DET_IRQ_EN
    logic              irq;
    logic              irq_clr;
`endif

    seq_detect_ctrl #(.DATA_W(DATA_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_count   (out_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
`ifdef SEQ_DET_IRQ_EN
        .irq         (irq),
        .irq_clr     (irq_clr),
`endif
        .match_pulse (match_pulse)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int expQ[$];
    logic [31:0] hist = '0;
    int histLen = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: count completed "1001" windows in the bit history since the last clear.
    function automatic int modelWord(input logic [DATA_W-1:0] word);
        int cnt = 0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            hist = {hist[30:0], word[i]};
            histLen++;
            if (histLen >= 4 && hist[3:0] == 4'b1001)
                cnt++;
        end
        return cnt;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [DATA_W-1:0] word, input logic doFlush);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready)
            checkVal("in_ready_timeout", 32'(in_ready), 32'd1);
        in_data  = word;
        in_valid = 1'b1;
        flush    = doFlush;
        if (doFlush)
            histLen = 0;
        expQ.push_back(modelWord(word));
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        $display("issue word=0x%02h flush=%0d", word, doFlush);
        checkVal("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic collect(input int holdCycles);
        int n = 0;
        int pulses = 0;
        int exp;
        logic prevPulse = 1'b0;
        logic [CNT_W-1:0] firstCount;
        forever begin
            if (match_pulse)
                pulses++;
`ifdef SEQ_DET_IRQ_EN
            if (prevPulse)
                checkVal("irq_set", 32'(irq), 32'd1);
`endif
            prevPulse = match_pulse;
            if (out_valid || n >= 40)
                break;
            tick();
            n++;
        end
        checkVal("out_valid_timeout", 32'(out_valid), 32'd1);
        if (expQ.size() == 0) begin
            checkVal("scoreboard_empty", 32'd0, 32'd1);
            exp = 0;
        end else begin
            exp = expQ.pop_front();
        end
        firstCount = out_count;
        for (int i = 0; i < holdCycles; i++) begin
            in_data  = 8'hFF;
            in_valid = 1'b1;
            flush    = 1'b1;
            tick();
`ifdef SEQ_DET_IRQ_EN
            if (prevPulse)
                checkVal("irq_set", 32'(irq), 32'd1);
            prevPulse = 1'b0;
`endif
            checkVal("hold_out_valid", 32'(out_valid), 32'd1);
            checkVal("hold_out_count", 32'(out_count), 32'(firstCount));
            checkVal("hold_in_ready", 32'(in_ready), 32'd0);
            checkVal("hold_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        checkVal("out_count", 32'(out_count), 32'(exp));
        checkVal("match_pulses", 32'(pulses), 32'(exp));
        $display("collect count=%0d pulses=%0d expected=%0d", out_count, pulses, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`ifdef SEQ_DET_IRQ_EN
        if (prevPulse)
            checkVal("irq_set", 32'(irq), 32'd1);
`endif
        checkVal("out_valid_drop", 32'(out_valid), 32'd0);
        checkVal("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int last;
        int hits;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
`ifdef SEQ_DET_IRQ_EN
        irq_clr   = 1'b0;
`endif
        tick();
        tick();
        checkVal("rst_in_ready", 32'(in_ready), 32'd1);
        checkVal("rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("rst_out_count", 32'(out_count), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_match_pulse", 32'(match_pulse), 32'd0);
`ifdef SEQ_DET_IRQ_EN
        checkVal("rst_irq", 32'(irq), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Basic, overlap, and straddle with/without flush
        issue(8'h99, 1'b0); collect(0);
        issue(8'h92, 1'b1); collect(0);
        issue(8'h01, 1'b1); collect(0);
        issue(8'h20, 1'b0); collect(0);
        issue(8'h01, 1'b1); collect(0);
        issue(8'h20, 1'b1); collect(0);

        // Back-pressure in REPORT with in_valid/flush presented
        issue(8'h99, 1'b1); collect(5);

        // Reset in the middle of a word
        issue(8'h99, 1'b1);
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        checkVal("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkVal("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("mid_rst_out_count", 32'(out_count), 32'd0);
        checkVal("mid_rst_busy", 32'(busy), 32'd0);
        checkVal("mid_rst_match_pulse", 32'(match_pulse), 32'd0);
        void'(expQ.pop_front());
        histLen = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        issue(8'h09, 1'b0); collect(0);

        // Throughput with in_valid and out_ready held high
        out_ready = 1'b1;
        in_data   = 8'h99;
        in_valid  = 1'b1;
        t = 0; last = 0; hits = 0;
        while (hits < 3 && t < 100) begin
            if (in_ready) begin
                if (hits > 0) begin
                    checkVal("throughput", 32'(t - last), 32'(DATA_W + 2));
                    $display("throughput interval=%0d", t - last);
                end
                last = t;
                hits++;
                if (hits == 3)
                    in_valid = 1'b0;
            end
            tick();
            t++;
        end
        checkVal("throughput_timeout", 32'(hits), 32'd3);
        in_valid  = 1'b0;
        out_ready = 1'b0;

`ifdef SEQ_DET_IRQ_EN
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        checkVal("irq_cleared", 32'(irq), 32'd0);
        issue(8'h99, 1'b1); collect(0);
        checkVal("irq_sticky", 32'(irq), 32'd1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        checkVal("irq_cleared2", 32'(irq), 32'd0);
        irq_clr = 1'b1;
        issue(8'h99, 1'b1); collect(0);
        irq_clr = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
